// File: rtl/ps2_kbd_fifo_if.sv
// Key-event handshake between the PS/2 receiver and its consumer.
//   ev_valid : FIFO head holds an event
//   ev_ready : consumer accepts the head this cycle
//   ev_code  : scan code of the head event
//   ev_break : head event is a key release
//   ev_ext   : head event is an extended key
// master = event source (receiver), slave = event sink (consumer).
interface ps2_kbd_fifo_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_break;
  logic       ev_ext;

  modport master (output ev_valid, ev_code, ev_break, ev_ext, input ev_ready);
  modport slave  (input ev_valid, ev_code, ev_break, ev_ext, output ev_ready);
endinterface

// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard receiver with scan-code prefix decoding and event FIFO.
//
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   ps2clk     : raw PS/2 clock (asynchronous)
//   ps2data    : raw PS/2 data (asynchronous)
//   ev         : key-event handshake (master side), show-ahead FIFO head
//   fifo_count : number of buffered events
//   err_parity : sticky, a frame was dropped for bad parity
//   err_frame  : sticky, a frame was dropped for bad stop bit or timeout
//   overflow   : sticky, an event was dropped because the FIFO was full
//   clear_err  : synchronous clear of the sticky flags (a same-cycle set wins)
//
// Frame FSM:
//   state  | meaning
//   IDLE   | waiting for a start bit (data low on a sample strobe)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | capturing the odd-parity bit
//   STOP   | checking stop bit and parity, emitting the byte if good
module ps2_kbd_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 15000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2clk,
  input  logic                          ps2data,
  ps2_kbd_fifo_if.master                ev,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          overflow,
  input  logic                          clear_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning: 2-flop synchronisers, clock glitch filter, fall strobe.
  // Synchronisers reset high so the idle bus does not look like an edge.
  // ---------------------------------------------------------------------------
  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          flt;
  logic [FW-1:0] flt_cnt;
  logic          smp_stb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2data;
      data_s2 <= data_s1;
    end
  end

  // flt_cnt counts consecutive samples that disagree with the filtered level;
  // the level flips on the FILTER_LEN-th one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flt     <= 1'b1;
      flt_cnt <= '0;
      smp_stb <= 1'b0;
    end else begin
      smp_stb <= flt && !clk_s2 && (flt_cnt == FLT_LAST);
      if (clk_s2 == flt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        flt     <= clk_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM with timeout down-counter and sticky frame/parity errors.
  // ---------------------------------------------------------------------------
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;
  logic          byte_valid;
  logic          pfx_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tmo_cnt    <= TMO_LOAD;
      byte_valid <= 1'b0;
      pfx_clr    <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      pfx_clr    <= 1'b0;
      // Clear first so an error raised in the same cycle overrides it.
      if (clear_err) begin
        err_parity <= 1'b0;
        err_frame  <= 1'b0;
      end
      if (smp_stb) begin
        tmo_cnt <= TMO_LOAD;
        case (state)
          IDLE: begin
            if (!data_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {data_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= data_s2;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!(^{shreg, par_bit})) begin
              err_parity <= 1'b1;
              pfx_clr    <= 1'b1;
            end else if (!data_s2) begin
              err_frame <= 1'b1;
              pfx_clr   <= 1'b1;
            end else begin
              byte_valid <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (tmo_cnt == '0) begin
          state     <= IDLE;
          err_frame <= 1'b1;
          pfx_clr   <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt - TW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prefix decoder: E0/F0 set flags, any other byte becomes an event.
  // ---------------------------------------------------------------------------
  logic       pfx_ext, pfx_brk;
  logic       push;
  logic [9:0] push_word;

  assign push      = byte_valid && (shreg != 8'hE0) && (shreg != 8'hF0);
  assign push_word = {pfx_ext, pfx_brk, shreg};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pfx_ext <= 1'b0;
      pfx_brk <= 1'b0;
    end else if (pfx_clr) begin
      pfx_ext <= 1'b0;
      pfx_brk <= 1'b0;
    end else if (byte_valid) begin
      if (shreg == 8'hE0) begin
        pfx_ext <= 1'b1;
      end else if (shreg == 8'hF0) begin
        pfx_brk <= 1'b1;
      end else begin
        pfx_ext <= 1'b0;
        pfx_brk <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead event FIFO. Storage is reset so the head reads 0 after reset.
  // ---------------------------------------------------------------------------
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          full, pop, do_push;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = (count != '0) && ev.ev_ready;
  // When full, a push only fits if the head leaves in the same cycle.
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (clear_err) overflow <= 1'b0;
      if (push && full && !pop) overflow <= 1'b1;
      if (do_push) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(pop);
    end
  end

  assign ev.ev_valid = (count != '0);
  assign ev.ev_code  = mem[rd_ptr][7:0];
  assign ev.ev_break = mem[rd_ptr][8];
  assign ev.ev_ext   = mem[rd_ptr][9];
  assign fifo_count  = count;

endmodule

// File: doc/ps2_kbd_fifo.md
Name: ps2_kbd_fifo

Overview:
- Parametrised PS/2 keyboard receiver: synchroniser, clock glitch filter, and an 11-bit frame FSM with parity, stop and timeout checking.
- Decodes E0/F0 prefixes into single key events and buffers them in a show-ahead FIFO with a valid/ready output.
- Replaces the ad-hoc in-display receiver. It feeds the text-console writer and the seven-segment debug logic.

Parameters:
- FIFO_DEPTH, 8, event FIFO depth; power of two, at least 2.
- FILTER_LEN, 4, number of consecutive equal synchronised ps2clk samples needed to change the filtered clock; at least 1.
- TIMEOUT_CYCLES, 15000, clk cycles without a filtered falling edge mid-frame before the frame is aborted.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ps2clk  in  1  raw PS/2 clock (asynchronous).
- ps2data  in  1  raw PS/2 data (asynchronous).
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts the head this cycle.
- ev_code  out  8  scan code of the head event.
- ev_break  out  1  head event is a release (F0 prefix).
- ev_ext  out  1  head event is extended (E0 prefix).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of events stored.
- err_parity  out  1  sticky: a frame was dropped for bad parity.
- err_frame  out  1  sticky: a frame was dropped for bad stop bit or timeout.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- clear_err  in  1  synchronous clear of the three sticky flags.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM to IDLE; FIFO emptied; prefix flags cleared; filter state set to 1.
  - All outputs 0.
  - Release is synchronous to clk.
- Input conditioning:
  - ps2clk and ps2data each pass through a 2-flop synchroniser.
  - Filtered clock changes only after FILTER_LEN consecutive equal samples.
  - A falling edge of the filtered clock produces a 1-cycle sample strobe; synchronised ps2data is sampled on that strobe.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: strobe with data=0 → DATA, bit counter=0. Strobe with data=1 → stay in IDLE, no error.
  - DATA: shift data in LSB first; after the 8th bit → PARITY.
  - PARITY: capture bit → STOP.
  - STOP: on strobe, the frame is good if data=1 and (data byte XOR parity) has odd popcount. Either way → IDLE.
    - Good frame: a byte-valid pulse is registered on the next cycle.
    - Bad parity: set err_parity, drop the byte, clear prefix flags.
    - Stop bit = 0 (parity good): set err_frame, drop the byte, clear prefix flags.
- Timeout:
  - A cycle counter runs in any state other than IDLE and resets on each strobe.
  - On reaching TIMEOUT_CYCLES: → IDLE, set err_frame, clear prefix flags, no byte emitted.
- Decoder, acting on byte-valid:
  - 0xE0 sets ext; 0xF0 sets brk; neither pushes an event.
  - Any other byte pushes {ext, brk, code} and clears both flags.
  - Repeated prefixes are idempotent.
  - 0xE1 and all other codes are pushed as plain events.
- Latency: stop bit sampled in cycle N → byte-valid in N+1 (FIFO write) → ev_valid=1 in N+2.
- FIFO:
  - Show-ahead: ev_code, ev_break and ev_ext present the head whenever ev_valid=1. They are don't-care and held when empty.
  - Pop when ev_valid and ev_ready.
  - Push when full and no pop: event dropped, overflow set, contents unchanged.
  - Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
  - Push and pop in the same cycle when not empty: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - ev_ready while empty has no effect.
- Sticky flags: clear_err clears all three. If an error event and clear_err occur in the same cycle, the set wins.

Test Plan:
- Make code 0x1C: frame 0,{0,0,1,1,1,0,0,0},0,1 with a 40-cycle half period → ev_valid=1 two cycles after the stop strobe; ev_code=0x1C, break=0, ext=0, fifo_count=1; ev_ready pops it, count=0.
- Extended release: send E0 (parity 0), F0 (parity 1), 75 (parity 0) → exactly one event, code=0x75, break=1, ext=1; prefix flags clear afterwards.
- Bad parity on 0x1C (parity bit 1) → no event, err_parity=1; clear_err → err_parity=0; next good frame is accepted.
- Timeout: stop ps2clk after 5 bits → after TIMEOUT_CYCLES, err_frame=1 and FSM in IDLE; a following full frame 0x16 decodes correctly.
- Overflow: with ev_ready=0, send FIFO_DEPTH+1 makes (0x16, 0x1E, …) → count=8, overflow=1; draining yields the first 8 codes in order.
- Glitch and reset: 2-cycle ps2clk low pulses (FILTER_LEN=4) → no strobe. rst=0 mid-frame and with FIFO non-empty → outputs 0, count=0 immediately; a next frame after release decodes.
